// File: rtl/rom_load_sequencer_if.sv
// rtl/rom_load_sequencer_if.sv - ioctl download bus and ROM write port bundle
interface rom_load_sequencer_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [2:0]  rom_we;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_wr_ready;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, rom_wr_ready,
        input  ioctl_wait, rom_we, rom_addr, rom_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, rom_wr_ready,
        output ioctl_wait, rom_we, rom_addr, rom_data
    );
endinterface

// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - ROM download sequencer with region decode and core reset stretch
module rom_load_sequencer #(
    parameter logic [31:0] CPU_SIZE = 32'h10000,
    parameter logic [31:0] SND_SIZE = 32'h01000,
    parameter logic [31:0] GFX_SIZE = 32'h08000,
    parameter int          RST_HOLD = 256
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    rom_load_sequencer_if.slave  bus,
    output logic [7:0]           mod,
    output logic [63:0]          dip,
    output logic                 core_reset,
    output logic                 load_error
);
    localparam int            CW        = $clog2(RST_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD - 1);

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_DRAIN, S_HOLD} state_t;

    state_t      state;
    logic [CW-1:0] hold_cnt;
    logic [2:0]  we_q;
    logic [24:0] addr_q;
    logic [7:0]  data_q;
    logic        wait_q;
    logic        dl_q;

    logic [31:0] a32;
    logic [2:0]  region;
    logic [24:0] offset;
    logic        in_range;
    logic        dl0;
    logic        rom_hit;
    logic        complete;
    logic        accept_ok;
    logic        take;
    logic        nxt_valid;

    always_comb begin
        a32      = {7'd0, bus.ioctl_addr};
        region   = 3'b000;
        offset   = 25'd0;
        in_range = 1'b1;
        if (a32 < CPU_SIZE) begin
            region = 3'b001;
            offset = a32[24:0];
        end else if (a32 < CPU_SIZE + SND_SIZE) begin
            region = 3'b010;
            offset = 25'(a32 - CPU_SIZE);
        end else if (a32 < CPU_SIZE + SND_SIZE + GFX_SIZE) begin
            region = 3'b100;
            offset = 25'(a32 - CPU_SIZE - SND_SIZE);
        end else begin
            in_range = 1'b0;
        end
        dl0       = bus.ioctl_download && (bus.ioctl_index == 8'd0);
        rom_hit   = bus.ioctl_wr && (bus.ioctl_index == 8'd0) && (state == S_LOAD);
        complete  = (we_q != 3'b000) && bus.rom_wr_ready;
        // A completing entry frees the slot in the same cycle, so back-to-back bytes see no bubble.
        accept_ok = (we_q == 3'b000) || complete;
        take      = rom_hit && in_range && accept_ok;
        nxt_valid = take || ((we_q != 3'b000) && !bus.rom_wr_ready);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_HOLD;
            hold_cnt   <= HOLD_LOAD;
            core_reset <= 1'b1;
            we_q       <= 3'b000;
            addr_q     <= 25'd0;
            data_q     <= 8'd0;
            wait_q     <= 1'b0;
            dl_q       <= 1'b0;
            mod        <= 8'hFF;
            dip        <= 64'd0;
            load_error <= 1'b0;
        end else begin
            dl_q   <= dl0;
            wait_q <= nxt_valid;

            if (dl0 && !dl_q) load_error <= 1'b0;
            if (rom_hit && !take) load_error <= 1'b1;

            if (take) begin
                we_q   <= region;
                addr_q <= offset;
                data_q <= bus.ioctl_dout;
            end else if (complete) begin
                we_q <= 3'b000;
            end

            if (bus.ioctl_wr && bus.ioctl_index == 8'd1) mod <= bus.ioctl_dout;
            if (bus.ioctl_wr && bus.ioctl_index == 8'd254 && bus.ioctl_addr[24:3] == 22'd0)
                dip[{bus.ioctl_addr[2:0], 3'b000} +: 8] <= bus.ioctl_dout;

            case (state)
                S_RUN: begin
                    if (dl0) begin
                        state      <= S_LOAD;
                        core_reset <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!bus.ioctl_download) begin
                        state    <= nxt_valid ? S_DRAIN : S_HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (!nxt_valid) begin
                        state    <= S_HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                S_HOLD: begin
                    if (dl0) begin
                        state <= S_LOAD;
                    end else if (hold_cnt == '0) begin
                        state      <= S_RUN;
                        core_reset <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end

    assign bus.rom_we     = we_q;
    assign bus.rom_addr   = addr_q;
    assign bus.rom_data   = data_q;
    assign bus.ioctl_wait = wait_q;
endmodule
